// File: rtl/hack_pkg.sv
// Shared mode encodings and the per-lane operation used by the mask pipe.
package hack_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  function automatic logic lane_op(input logic x, input logic g, input mode_e m);
    logic r;
    case (m)
      MODE_AND: r = x & g;
      MODE_OR:  r = x | g;
      MODE_XOR: r = x ^ g;
      default:  r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous flush and async reset.
// Storage is never reset; the head reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  // A flush cycle swallows any push or pop presented alongside it.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/and_mask_pipe.sv
// Applies a broadcast gate bit to every lane of a word (AND/OR/XOR/PASS)
// and queues the results in a small output buffer with valid/ready handshakes.
module and_mask_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       a,
  input  logic                   b,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  import hack_pkg::*;

  logic [WIDTH-1:0] result;
  logic             full;
  logic             empty;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign result[gi] = lane_op(a[gi], b, mode_e'(mode));
    end
  endgenerate

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (in_valid),
    .pop     (out_ready),
    .wr_data (result),
    .rd_data (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // No pass-through: a full buffer refuses input even while it is draining.
  assign in_ready  = !full;
  assign out_valid = !empty;

endmodule

// File: tb/tb_and_mask_pipe.sv
// Scoreboarded bench for and_mask_pipe: directed corner cases then random traffic.
module tb_and_mask_pipe;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  a = '0;
  logic          b = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] count;

  int            n_vec = 0;
  int            n_fail = 0;
  logic [W-1:0]  sb_q[$];

  always #5 clk = ~clk;

  and_mask_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic g, input logic [1:0] m);
    case (m)
      2'd0:    return g ? x : '0;
      2'd1:    return g ? {W{1'b1}} : x;
      2'd2:    return g ? ~x : x;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and records the expected word.
  task automatic cycle(input logic iv, input logic [W-1:0] av, input logic bv,
                       input logic [1:0] mv, input logic ordy, input logic fl);
    logic acc;
    in_valid  = iv;
    a         = av;
    b         = bv;
    mode      = mv;
    out_ready = ordy;
    flush     = fl;
    acc = iv && !fl && (sb_q.size() < D);
    @(posedge clk);
    if (fl) sb_q.delete();
    else if (acc) sb_q.push_back(ref_op(av, bv, mv));
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("count", 32'(count), 32'(sb_q.size()));
      chk("in_ready", 32'(in_ready), 32'(sb_q.size() < D));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("out_data", 32'(out_data), (sb_q.size() == 0) ? 32'd0 : 32'(sb_q[0]));
      if (sb_q.size() != 0 && out_ready && !flush) void'(sb_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Lane operations with one-cycle latency
    cycle(1'b1, 16'hA5F0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("and_b0_valid", 32'(out_valid), 32'd1);
    chk("and_b0", 32'(out_data), 32'h0000);
    cycle(1'b1, 16'hA5F0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("and_b1", 32'(out_data), 32'hA5F0);
    cycle(1'b1, 16'h1234, 1'b1, 2'd1, 1'b1, 1'b0);
    chk("or_b1", 32'(out_data), 32'hFFFF);
    cycle(1'b1, 16'h00FF, 1'b1, 2'd2, 1'b1, 1'b0);
    chk("xor_b1", 32'(out_data), 32'hFF00);
    cycle(1'b1, 16'h1234, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("pass_b0", 32'(out_data), 32'h1234);
    cycle(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("drained", 32'(count), 32'd0);

    // Fill to capacity; fifth word must be refused
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 2'd3, 1'b0, 1'b0);
      if (i == 3) begin
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
      end
    end
    chk("fifth_ignored", 32'(count), 32'd4);
    cycle(1'b1, 16'h2000, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("full_pop_only", 32'(count), 32'd3);
    cycle(1'b1, 16'h2001, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("push_pop_same", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("drain_empty", 32'(count), 32'd0);

    // Flush with a simultaneous push
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h3000 + 16'(i), 1'b1, 2'd2, 1'b0, 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 2'd3, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", 32'(out_data), 32'd0);

    // Asynchronous reset in the middle of a cycle with two entries held
    for (int i = 0; i < 2; i++) cycle(1'b1, 16'h4000 + 16'(i), 1'b0, 2'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    sb_q.delete();
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_rel_count", 32'(count), 32'd0);
    cycle(1'b1, 16'hBEEF, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("post_rst_first", 32'(out_data), 32'hBEEF);

    // Random traffic against the scoreboard
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom), 2'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < D + 1; i++) cycle(1'b0, '0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("final_empty", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
